fetch_redirect: RTL and testbench

Control block driving the fetch stage's PC-select interface (`next_PC_select`, `target_PC`). It sits between decode/execute and fetch. It arbitrates jump, branch and trap redirect requests, then issues a single-cycle PC redirect to fetch. After each redirect it asserts a multi-cycle flush that squashes wrong-path instructions in the front-end pipeline.

---
 rtl/fetch_redirect_pkg.sv | 20 ++
 rtl/redirect_arbiter.sv | 63 ++++++
 rtl/fetch_redirect.sv | 118 +++++++++++
 tb/tb_fetch_redirect.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_pkg.sv
// Shared types for the fetch redirect controller: FSM states,
// redirect causes and the default trap vector.
package fetch_redirect_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_FLUSH
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_JUMP,
        CAUSE_BRANCH,
        CAUSE_TRAP
    } cause_e;

    localparam logic [15:0] DEFAULT_TRAP_VECTOR = 16'h0010;

endpackage

// File: rtl/redirect_arbiter.sv
// Priority select of trap > taken branch > jump, plus target alignment.
// FETCH_REDIRECT_MISALIGN_EN turns unaligned targets into a trap redirect.
module redirect_arbiter
    import fetch_redirect_pkg::*;
#(
    parameter int                    ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] TRAP_VECTOR =
        ADDRESS_BITS'(DEFAULT_TRAP_VECTOR)
) (
    input  logic                    busy_i,
    input  logic                    jump_valid_i,
    input  logic [ADDRESS_BITS-1:0] jump_target_i,
    input  logic                    branch_valid_i,
    input  logic                    branch_taken_i,
    input  logic [ADDRESS_BITS-1:0] branch_target_i,
    input  logic                    trap_valid_i,
    output cause_e                  cause_o,
    output logic [ADDRESS_BITS-1:0] target_o,
    output logic                    misaligned_o
);

    logic req_trap;
    logic req_branch;
    logic req_jump;

    // Wrong-path jumps/branches are masked while a redirect is in flight.
    assign req_trap   = trap_valid_i;
    assign req_branch = !req_trap && !busy_i
                        && branch_valid_i && branch_taken_i;
    assign req_jump   = !req_trap && !req_branch && !busy_i
                        && jump_valid_i;

    always_comb begin
        cause_o      = CAUSE_NONE;
        target_o     = '0;
        misaligned_o = 1'b0;
        unique case (1'b1)
            req_trap: begin
                cause_o  = CAUSE_TRAP;
                target_o = TRAP_VECTOR;
            end
            req_branch: begin
                cause_o  = CAUSE_BRANCH;
                target_o = branch_target_i;
            end
            req_jump: begin
                cause_o  = CAUSE_JUMP;
                target_o = jump_target_i;
            end
            default: ;
        endcase
`ifdef FETCH_REDIRECT_MISALIGN_EN
        if ((cause_o == CAUSE_JUMP || cause_o == CAUSE_BRANCH)
            && (target_o[1:0] != 2'b00)) begin
            target_o     = TRAP_VECTOR;
            misaligned_o = 1'b1;
        end
`else
        target_o[1:0] = 2'b00;
`endif
    end

endmodule

// File: rtl/fetch_redirect.sv
// Redirect FSM: one-cycle PC-select pulse followed by a counted flush.
// Optional FETCH_REDIRECT_MISALIGN_EN traps on unaligned targets.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter int                    ADDRESS_BITS = 16,
    parameter int                    FLUSH_CYCLES = 2,
    parameter logic [ADDRESS_BITS-1:0] TRAP_VECTOR =
        ADDRESS_BITS'(DEFAULT_TRAP_VECTOR)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic                    jump_valid,
    input  logic [ADDRESS_BITS-1:0] jump_target,
    input  logic                    branch_valid,
    input  logic                    branch_taken,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic                    trap_valid,
    output logic                    next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    flush,
    output logic [ADDRESS_BITS-1:0] trap_epc,
    output logic                    misaligned
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    sel_q;
    logic [ADDRESS_BITS-1:0] target_q;
    logic                    flush_q;
    logic [ADDRESS_BITS-1:0] epc_q;
    logic                    mis_q;

    logic                    busy;
    cause_e                  arb_cause;
    logic [ADDRESS_BITS-1:0] arb_target;
    logic                    arb_mis;

    // Requests open up again during the last flush cycle.
    assign busy = ((state_q == S_REDIRECT) && (FLUSH_CYCLES > 1))
               || ((state_q == S_FLUSH) && (cnt_q > CW'(1)));

    redirect_arbiter #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_arb (
        .busy_i          (busy),
        .jump_valid_i    (jump_valid),
        .jump_target_i   (jump_target),
        .branch_valid_i  (branch_valid),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .trap_valid_i    (trap_valid),
        .cause_o         (arb_cause),
        .target_o        (arb_target),
        .misaligned_o    (arb_mis)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            target_q <= '0;
            flush_q  <= 1'b0;
            epc_q    <= '0;
            mis_q    <= 1'b0;
        end else begin
            sel_q <= 1'b0;
            mis_q <= 1'b0;
            if (arb_cause != CAUSE_NONE) begin
                state_q  <= S_REDIRECT;
                cnt_q    <= '0;
                sel_q    <= 1'b1;
                target_q <= arb_target;
                flush_q  <= 1'b1;
                mis_q    <= arb_mis;
                if (arb_cause == CAUSE_TRAP || arb_mis)
                    epc_q <= PC;
            end else begin
                unique case (state_q)
                    S_REDIRECT: begin
                        if (FLUSH_CYCLES > 1) begin
                            state_q <= S_FLUSH;
                            cnt_q   <= CW'(FLUSH_CYCLES - 1);
                        end else begin
                            state_q <= S_IDLE;
                            flush_q <= 1'b0;
                        end
                    end
                    S_FLUSH: begin
                        if (cnt_q <= CW'(1)) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            flush_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign next_PC_select = sel_q;
    assign target_PC      = target_q;
    assign flush          = flush_q;
    assign trap_epc       = epc_q;
    assign misaligned     = mis_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Scoreboard bench for fetch_redirect: expected redirects and flush
// run lengths are queued by the stimulus and checked by a monitor.
module tb_fetch_redirect;

    typedef struct {
        logic [15:0] tgt;
        logic [15:0] epc;
        logic        mis;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] PC = '0;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_target = '0;
    logic        branch_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        trap_valid = 1'b0;
    logic        next_PC_select;
    logic [15:0] target_PC;
    logic        flush;
    logic [15:0] trap_epc;
    logic        misaligned;

    int vectors = 0;
    int errors  = 0;

    exp_t redir_q[$];
    int   flen_q[$];
    logic [15:0] exp_epc = '0;

    fetch_redirect #(
        .ADDRESS_BITS (16),
        .FLUSH_CYCLES (2),
        .TRAP_VECTOR  (16'h0010)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .PC             (PC),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .branch_valid   (branch_valid),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .trap_valid     (trap_valid),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .flush          (flush),
        .trap_epc       (trap_epc),
        .misaligned     (misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: samples just after each rising edge.
    int run = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                run = 0;
            end else begin
                if (next_PC_select) begin
                    if (redir_q.size() == 0) begin
                        check("unexpected_redirect", target_PC, 16'hxxxx);
                    end else begin
                        e = redir_q.pop_front();
                        check("target_PC", target_PC, e.tgt);
                        check("trap_epc", trap_epc, e.epc);
                        check("misaligned", {15'd0, misaligned},
                              {15'd0, e.mis});
                    end
                end
                if (flush) begin
                    run++;
                end else if (run > 0) begin
                    if (flen_q.size() == 0)
                        check("unexpected_flush", 16'(run), 16'd0);
                    else
                        check("flush_len", 16'(run),
                              16'(flen_q.pop_front()));
                    run = 0;
                end
            end
        end
    end

    task automatic exp_redir(input logic [15:0] t, input logic m);
        exp_t e;
        e.tgt = t;
        e.epc = exp_epc;
        e.mis = m;
        redir_q.push_back(e);
    endtask

    task automatic step(input logic jv, input logic [15:0] jt,
                        input logic bv, input logic bt,
                        input logic [15:0] btg, input logic tv,
                        input logic [15:0] pc);
        @(negedge clock);
        jump_valid    = jv;
        jump_target   = jt;
        branch_valid  = bv;
        branch_taken  = bt;
        branch_target = btg;
        trap_valid    = tv;
        PC            = pc;
    endtask

    task automatic clr();
        step(0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // Reset and quiet idle
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_sel", {15'd0, next_PC_select}, 16'd0);
        check("rst_target", target_PC, 16'd0);
        check("rst_flush", {15'd0, flush}, 16'd0);
        check("rst_epc", trap_epc, 16'd0);
        check("rst_mis", {15'd0, misaligned}, 16'd0);

        // Simple jump
        exp_redir(16'h0100, 1'b0);
        flen_q.push_back(2);
        step(1, 16'h0100, 0, 0, 16'h0, 0, 16'h0);
        clr();
        idle(5);

        // Branch beats jump in the same cycle
        exp_redir(16'h0200, 1'b0);
        flen_q.push_back(2);
        step(1, 16'h0300, 1, 1, 16'h0200, 0, 16'h0);
        clr();
        idle(5);

        // Not-taken branch is no request
        step(0, 16'h0, 1, 0, 16'h0700, 0, 16'h0);
        clr();
        idle(5);

        // Second jump during flush is dropped
        exp_redir(16'h0100, 1'b0);
        flen_q.push_back(2);
        step(1, 16'h0100, 0, 0, 16'h0, 0, 16'h0);
        step(1, 16'h0400, 0, 0, 16'h0, 0, 16'h0);
        clr();
        idle(5);

        // Trap during flush restarts the redirect
        exp_redir(16'h0100, 1'b0);
        exp_epc = 16'h0104;
        exp_redir(16'h0010, 1'b0);
        flen_q.push_back(3);
        step(1, 16'h0100, 0, 0, 16'h0, 0, 16'h0);
        step(0, 16'h0, 0, 0, 16'h0, 1, 16'h0104);
        clr();
        idle(5);

        // Unaligned jump target
`ifdef FETCH_REDIRECT_MISALIGN_EN
        exp_epc = 16'h0300;
        exp_redir(16'h0010, 1'b1);
`else
        exp_redir(16'h0100, 1'b0);
`endif
        flen_q.push_back(2);
        step(1, 16'h0102, 0, 0, 16'h0, 0, 16'h0300);
        clr();
        idle(5);

        // Jump accepted in the last flush cycle: back-to-back redirect
        exp_redir(16'h0100, 1'b0);
        exp_redir(16'h0500, 1'b0);
        flen_q.push_back(4);
        step(1, 16'h0100, 0, 0, 16'h0, 0, 16'h0);
        clr();
        step(1, 16'h0500, 0, 0, 16'h0, 0, 16'h0);
        clr();
        idle(6);

        // Reset asserted mid-flush: nothing survives
        exp_redir(16'h0600, 1'b0);
        step(1, 16'h0600, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clock);
        jump_valid = 1'b0;
        reset = 1'b0;
        exp_epc = 16'h0;
        idle(2);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_sel", {15'd0, next_PC_select}, 16'd0);
        check("post_rst_target", target_PC, 16'd0);
        check("post_rst_flush", {15'd0, flush}, 16'd0);
        check("post_rst_epc", trap_epc, 16'd0);

        // Trap from idle
        exp_epc = 16'h0200;
        exp_redir(16'h0010, 1'b0);
        flen_q.push_back(2);
        step(0, 16'h0, 0, 0, 16'h0, 1, 16'h0200);
        clr();
        idle(6);

        check("redir_q_empty", 16'(redir_q.size()), 16'd0);
        check("flen_q_empty", 16'(flen_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
